video_render: RTL and testbench

Pixel-serialising stage directly downstream of the video fetch unit. Captures the 64-bit `pic_bits` word on every `fetch_sync` and shifts it out as one 4-bit colour index per pixel strobe. Decodes three picture formats: ZX attribute, 16-colour and hi-res mono. Outputs the border colour outside the pixel window. Feeds the palette/frame stage.

---
 rtl/video_render_if.sv | 24 ++
 rtl/video_render.sv | 94 +++++++++
 tb/tb_video_render.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_render_if.sv
// Picture data and pixel-output bundle between the fetch unit, the
// serialiser and the downstream palette stage.
interface video_render_if;
   logic        cend;
   logic        pre_cend;
   logic        fetch_sync;
   logic [63:0] pic_bits;
   logic [1:0]  mode;
   logic        pix_en;
   logic [3:0]  border;
   logic        flash;
   logic [3:0]  color;
   logic        color_stb;

   modport master (
      output cend, pre_cend, fetch_sync, pic_bits, mode, pix_en, border, flash,
      input  color, color_stb
   );

   modport slave (
      input  cend, pre_cend, fetch_sync, pic_bits, mode, pix_en, border, flash,
      output color, color_stb
   );
endinterface

// File: rtl/video_render.sv
// Pixel serialiser: latches a 64-bit fetch word into a shadow buffer and
// emits one 4-bit colour index per pixel strobe, decoding ZX attribute,
// 16-colour or hi-res mono layouts, with border outside the pixel window.
module video_render (
   input  logic          clk,
   input  logic          rst_n,
   video_render_if.slave vif
);
   localparam logic [1:0] MODE_16C   = 2'b01;
   localparam logic [1:0] MODE_HIRES = 2'b10;

   // ZX: byte pair per 8-pixel cell, attribute selects ink/paper and bright
   function automatic logic [3:0] decode_zx(input logic [63:0] sh,
                                            input logic [3:0]  i,
                                            input logic        fl);
      logic [7:0] pix;
      logic [7:0] attr;
      logic       dot;
      pix  = sh[{1'b0, i[3], 4'b0000} +: 8];
      attr = sh[{1'b0, i[3], 4'b1000} +: 8];
      dot  = pix[~i[2:0]] ^ (attr[7] & fl);
      return {attr[6], dot ? attr[2:0] : attr[5:3]};
   endfunction

   // 16-colour: two pixels per byte, high nibble first
   function automatic logic [3:0] decode_16c(input logic [63:0] sh,
                                             input logic [3:0]  i);
      logic [7:0] byt;
      byt = sh[{i[3:1], 3'b000} +: 8];
      return i[0] ? byt[3:0] : byt[7:4];
   endfunction

   // Hi-res: bytes 0..3 are pixel bits, bytes 4..7 the matching attributes
   function automatic logic [3:0] decode_hires(input logic [63:0] sh,
                                               input logic [4:0]  i);
      logic [7:0] byt;
      logic [7:0] attr;
      byt  = sh[{1'b0, i[4:3], 3'b000} +: 8];
      attr = sh[{1'b1, i[4:3], 3'b000} +: 8];
      return byt[~i[2:0]] ? attr[3:0] : attr[7:4];
   endfunction

   logic [63:0] shadow_p0;
   logic [4:0]  idx_p0;
   logic        hires_p0;
   logic        ps_p0;
   logic [4:0]  idx_next_p0;
   logic [3:0]  pix_p0;
   logic [3:0]  color_p1;
   logic        vld_p1;

   // Strobe selection, index advance and pixel decode from the shadow buffer
   always_comb begin
      hires_p0    = (vif.mode == MODE_HIRES);
      ps_p0       = hires_p0 ? (vif.cend | vif.pre_cend) : vif.cend;
      // lo-res periods are 16 pixels, so idx[4] is dropped and never set
      idx_next_p0 = hires_p0 ? idx_p0 + 5'd1 : {1'b0, idx_p0[3:0] + 4'd1};
      case (vif.mode)
         MODE_16C:   pix_p0 = decode_16c(shadow_p0, idx_p0[3:0]);
         MODE_HIRES: pix_p0 = decode_hires(shadow_p0, idx_p0);
         default:    pix_p0 = decode_zx(shadow_p0, idx_p0[3:0], vif.flash);
      endcase
   end

   // Shadow load and pixel index; a load clears idx and overrides the advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_p0 <= '0;
         idx_p0    <= '0;
      end else if (vif.fetch_sync) begin
         shadow_p0 <= vif.pic_bits;
         idx_p0    <= '0;
      end else if (ps_p0) begin
         idx_p0    <= idx_next_p0;
      end
   end

   // ---- stage p0 -> p1: registered colour and one-clock strobe ----
   // Output register: border outside the window, decoded pixel inside
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         color_p1 <= '0;
         vld_p1   <= 1'b0;
      end else begin
         vld_p1 <= ps_p0;
         if (ps_p0) begin
            color_p1 <= vif.pix_en ? pix_p0 : vif.border;
         end
      end
   end

   assign vif.color     = color_p1;
   assign vif.color_stb = vld_p1;
endmodule

// File: tb/tb_video_render.sv
// Bench for video_render: cycle-accurate behavioural model of the pixel
// stream plus directed scenarios for each picture format and boundary case.
module tb_video_render;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   video_render_if vif();
   video_render dut (.clk(clk), .rst_n(rst_n), .vif(vif));

   int checks = 0;
   int failures = 0;
   int phase = 0;
   int cyc = 0;

   // behavioural model state
   logic [7:0] msh [8];
   int         midx;
   logic [3:0] mcol;
   logic       mstb;

   logic [3:0] emitted [$];
   int         stb_cycles [$];

   function automatic logic [3:0] ref_pixel(int m, int i, logic fl);
      int b, a, p, dot;
      case (m)
         1: begin
            b = int'(msh[i / 2]);
            return (i % 2 == 1) ? 4'(b % 16) : 4'(b / 16);
         end
         2: begin
            p = int'(msh[i / 8]);
            a = int'(msh[4 + i / 8]);
            dot = (p >> (7 - i % 8)) & 1;
            return (dot == 1) ? 4'(a % 16) : 4'(a / 16);
         end
         default: begin
            p = int'(msh[2 * (i / 8)]);
            a = int'(msh[2 * (i / 8) + 1]);
            dot = ((p >> (7 - i % 8)) & 1) ^ (((a >> 7) & 1) & int'(fl));
            return 4'(((a >> 6) & 1) * 8 + ((dot == 1) ? a % 8 : (a / 8) % 8));
         end
      endcase
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 8; k++) msh[k] = 8'h00;
      midx = 0;
      mcol = 4'h0;
      mstb = 1'b0;
   endtask

   // one clock: drive strobes, advance model on the edge, compare 1 time unit later
   task automatic step();
      bit hires, ps;
      int i, len;
      vif.cend     = (phase == 3);
      vif.pre_cend = (phase == 1);
      @(posedge clk);
      if (!rst_n) begin
         model_clear();
      end else begin
         hires = (vif.mode == 2'b10);
         ps    = hires ? (vif.cend | vif.pre_cend) : vif.cend;
         len   = hires ? 32 : 16;
         if (ps) begin
            i    = hires ? midx : midx % 16;
            mcol = vif.pix_en ? ref_pixel(int'(vif.mode), i, vif.flash) : vif.border;
            midx = (i + 1) % len;
            mstb = 1'b1;
         end else begin
            mstb = 1'b0;
         end
         if (vif.fetch_sync) begin
            for (int k = 0; k < 8; k++) msh[k] = vif.pic_bits[8*k +: 8];
            midx = 0;
         end
      end
      phase = (phase + 1) % 4;
      cyc++;
      #1;
      checks++;
      if (vif.color_stb !== mstb) begin
         failures++;
         $display("FAIL color_stb cyc=%0d: got %b expected %b", cyc, vif.color_stb, mstb);
      end
      checks++;
      if (vif.color !== mcol) begin
         failures++;
         $display("FAIL color cyc=%0d: got %h expected %h", cyc, vif.color, mcol);
      end
      if (vif.color_stb === 1'b1) begin
         emitted.push_back(vif.color);
         stb_cycles.push_back(cyc);
      end
   endtask

   task automatic run_strobes(int n);
      int got = 0;
      int budget = n * 8 + 8;
      while (got < n && budget > 0) begin
         step();
         if (vif.color_stb === 1'b1) got++;
         budget--;
      end
      checks++;
      if (got < n) begin
         failures++;
         $display("FAIL strobe_budget: got %0d strobes expected %0d", got, n);
      end
   endtask

   task automatic load(logic [63:0] bits);
      while (phase != 3) step();
      vif.fetch_sync = 1'b1;
      vif.pic_bits   = bits;
      step();
      vif.fetch_sync = 1'b0;
   endtask

   task automatic test_reset();
      model_clear();
      vif.cend = 0; vif.pre_cend = 0; vif.fetch_sync = 0; vif.pic_bits = '0;
      vif.mode = 2'b01; vif.pix_en = 0; vif.border = 4'hF; vif.flash = 0;
      repeat (3) step();
      rst_n = 1'b1;
      run_strobes(2);
      checks++;
      if (vif.color !== 4'hF) begin
         failures++;
         $display("FAIL pre_reset_border: got %h expected %h", vif.color, 4'hF);
      end
      #2;
      rst_n = 1'b0;
      model_clear();
      #1;
      checks++;
      if (vif.color !== 4'h0 || vif.color_stb !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: got color=%h stb=%b expected 0/0", vif.color, vif.color_stb);
      end
      repeat (2) step();
      rst_n = 1'b1;
      vif.border = 4'h5;
      emitted.delete();
      run_strobes(1);
      checks++;
      if (emitted.size() < 1 || emitted[0] !== 4'h5) begin
         failures++;
         $display("FAIL reset_first_border: got %h expected %h",
                  (emitted.size() > 0) ? emitted[0] : 4'hx, 4'h5);
      end
   endtask

   task automatic test_zx();
      logic [3:0] exp_a [8] = '{4'hF, 4'h8, 4'hF, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8};
      logic [3:0] exp_b [8] = '{4'h8, 4'hF, 4'h8, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
      vif.mode = 2'b00; vif.pix_en = 1; vif.flash = 0;
      load({$urandom, 16'($urandom), 8'h47, 8'hA0});
      emitted.delete();
      run_strobes(8);
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (emitted[k] !== exp_a[k]) begin
            failures++;
            $display("FAIL zx_plain[%0d]: got %h expected %h", k, emitted[k], exp_a[k]);
         end
      end
      vif.flash = 1;
      load({$urandom, 16'($urandom), 8'hC7, 8'hA0});
      emitted.delete();
      run_strobes(8);
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (emitted[k] !== exp_b[k]) begin
            failures++;
            $display("FAIL zx_flash[%0d]: got %h expected %h", k, emitted[k], exp_b[k]);
         end
      end
      vif.flash = 0;
   endtask

   task automatic test_16col();
      vif.mode = 2'b01; vif.pix_en = 1;
      load(64'hEFCD_AB89_6745_2301);
      emitted.delete();
      run_strobes(17);
      for (int k = 0; k < 17; k++) begin
         checks++;
         if (emitted[k] !== 4'(k % 16)) begin
            failures++;
            $display("FAIL c16_seq[%0d]: got %h expected %h", k, emitted[k], 4'(k % 16));
         end
      end
   endtask

   task automatic test_hires();
      int bad = 0;
      vif.mode = 2'b10; vif.pix_en = 1;
      load({24'($urandom), 8'h1E, 24'($urandom), 8'h80});
      emitted.delete();
      stb_cycles.delete();
      run_strobes(32);
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (emitted[k] !== ((k == 0) ? 4'hE : 4'h1)) begin
            failures++;
            $display("FAIL hires_pix[%0d]: got %h expected %h", k, emitted[k],
                     (k == 0) ? 4'hE : 4'h1);
         end
      end
      for (int k = 1; k < stb_cycles.size(); k++)
         if (stb_cycles[k] - stb_cycles[k-1] != 2) bad++;
      checks++;
      if (bad != 0 || stb_cycles.size() != 32) begin
         failures++;
         $display("FAIL hires_stb_spacing: got %0d irregular gaps over %0d strobes expected 0 over 32",
                  bad, stb_cycles.size());
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] a, b;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      vif.mode = 2'b01; vif.pix_en = 1;
      load(a);
      run_strobes(15);
      emitted.delete();
      load(b);
      run_strobes(1);
      checks++;
      if (emitted[0] !== a[59:56]) begin
         failures++;
         $display("FAIL b2b_old_pix15: got %h expected %h", emitted[0], a[59:56]);
      end
      checks++;
      if (emitted[1] !== b[7:4]) begin
         failures++;
         $display("FAIL b2b_new_pix0: got %h expected %h", emitted[1], b[7:4]);
      end
   endtask

   task automatic test_window();
      logic [3:0] brd;
      logic [3:0] exp;
      brd = 4'($urandom);
      vif.mode = 2'b01; vif.pix_en = 1;
      load(64'hEFCD_AB89_6745_2301);
      emitted.delete();
      run_strobes(4);
      vif.pix_en = 0; vif.border = brd;
      run_strobes(4);
      vif.pix_en = 1;
      run_strobes(4);
      for (int k = 0; k < 12; k++) begin
         exp = (k >= 4 && k < 8) ? brd : 4'(k);
         checks++;
         if (emitted[k] !== exp) begin
            failures++;
            $display("FAIL window[%0d]: got %h expected %h", k, emitted[k], exp);
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 39) == 0) vif.mode = 2'($urandom);
         if ($urandom_range(0, 9) == 0) vif.pix_en = ~vif.pix_en;
         vif.border = 4'($urandom);
         vif.flash  = 1'($urandom);
         vif.fetch_sync = (phase == 3) && ($urandom_range(0, 2) == 0);
         vif.pic_bits   = {$urandom, $urandom};
         step();
      end
      vif.fetch_sync = 0;
   endtask

   initial begin
      test_reset();
      test_zx();
      test_16col();
      test_hires();
      test_back_to_back();
      test_window();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
